// File: rtl/wishbone_pkg.sv
// Shared Wishbone bus types: the 69-bit request word exchanged between the
// master and slave transactors and the bus field widths.
package wishbone_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef struct packed {
    logic                we;
    logic [WB_SEL_W-1:0] sel;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
  } wb_req_t;

  localparam int WB_REQ_W = $bits(wb_req_t);

endpackage

// File: rtl/wb_sync_fifo.sv
// Synchronous FIFO with a storage-register head (no fall-through) and a
// synchronous flush. DEPTH must be a power of two so pointers wrap naturally.
module wb_sync_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 8
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       flush,
  input  logic                       push,
  input  T                           din,
  input  logic                       pop,
  output T                           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) mem_q <= mem_d;

endmodule

// File: rtl/wishbone_slave_xactor.sv
// Pipelined Wishbone B4 slave: turns accepted strobes into an in-order client
// request stream and client responses back into single-cycle ACKs.
module wishbone_slave_xactor
  import wishbone_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                CYC_I,
  input  logic                STB_I,
  input  logic                WE_I,
  input  logic [WB_ADR_W-1:0] ADR_I,
  input  logic [WB_SEL_W-1:0] SEL_I,
  input  logic [WB_DAT_W-1:0] DAT_I,
  output logic                STALL_O,
  output logic                ACK_O,
  output logic [WB_DAT_W-1:0] DAT_O,
  output logic [WB_REQ_W-1:0] client_request_get,
  output logic                RDY_client_request_get,
  input  logic                EN_client_request_get,
  input  logic [WB_DAT_W-1:0] client_response_put,
  output logic                RDY_client_response_put,
  input  logic                EN_client_response_put
);

  localparam int CW = $clog2(MAX_OUTSTANDING+1);

  logic [CW-1:0]       qcnt, total;
  logic [CW-1:0]       inflight_q, inflight_d;
  logic [CW-1:0]       drop_q, drop_d;
  logic                ack_q, ack_d;
  logic [WB_DAT_W-1:0] dat_q, dat_d;
  logic                accept, deq, put, fifo_empty, unused_fifo_full;
  wb_req_t             req, head;

  assign total   = qcnt + inflight_q + drop_q;
  // Stall depends only on registered counters, never on STB_I.
  assign STALL_O = !RST_N || (total == CW'(MAX_OUTSTANDING));
  assign accept  = CYC_I && STB_I && !STALL_O;
  assign deq     = EN_client_request_get;
  assign put     = EN_client_response_put;
  assign req     = '{we: WE_I, sel: SEL_I, adr: ADR_I, dat: DAT_I};

  wb_sync_fifo #(
    .T     (wb_req_t),
    .DEPTH (MAX_OUTSTANDING)
  ) u_req_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .flush (!CYC_I),
    .push  (accept),
    .din   (req),
    .pop   (deq),
    .dout  (head),
    .full  (unused_fifo_full),
    .empty (fifo_empty),
    .count (qcnt)
  );

  assign client_request_get      = head;
  assign RDY_client_request_get  = RST_N && !fifo_empty;
  assign RDY_client_response_put = RST_N && ((inflight_q + drop_q) != '0);
  assign ACK_O                   = ack_q;
  assign DAT_O                   = dat_q;

  always_comb begin
    inflight_d = inflight_q;
    drop_d     = drop_q;
    ack_d      = 1'b0;
    dat_d      = dat_q;
    if (!CYC_I) begin
      // Abort: everything the client holds, including a same-cycle dequeue,
      // becomes a response owed but never acknowledged.
      drop_d     = drop_q + inflight_q + CW'(deq) - CW'(put);
      inflight_d = '0;
    end else if (put && (drop_q != '0)) begin
      drop_d     = drop_q - 1'b1;
      inflight_d = inflight_q + CW'(deq);
    end else begin
      inflight_d = inflight_q + CW'(deq) - CW'(put);
      ack_d      = put;
      if (put) dat_d = client_response_put;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      inflight_q <= '0;
      drop_q     <= '0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
    end
  end

endmodule

// File: tb/tb_wishbone_slave_xactor.sv
// Directed and random bench for wishbone_slave_xactor against a queue-based
// model of bus requests, in-flight requests and owed (dropped) responses.
module tb_wishbone_slave_xactor;
  import wishbone_pkg::*;

  localparam int MAXO = 8;

  logic                CLK = 1'b0;
  logic                RST_N;
  logic                CYC_I, STB_I, WE_I;
  logic [WB_ADR_W-1:0] ADR_I;
  logic [WB_SEL_W-1:0] SEL_I;
  logic [WB_DAT_W-1:0] DAT_I;
  logic                STALL_O, ACK_O;
  logic [WB_DAT_W-1:0] DAT_O;
  logic [WB_REQ_W-1:0] client_request_get;
  logic                RDY_client_request_get, EN_client_request_get;
  logic [WB_DAT_W-1:0] client_response_put;
  logic                RDY_client_response_put, EN_client_response_put;

  always #5 CLK = ~CLK;

  wishbone_slave_xactor #(.MAX_OUTSTANDING(MAXO)) dut (
    .CLK                     (CLK),
    .RST_N                   (RST_N),
    .CYC_I                   (CYC_I),
    .STB_I                   (STB_I),
    .WE_I                    (WE_I),
    .ADR_I                   (ADR_I),
    .SEL_I                   (SEL_I),
    .DAT_I                   (DAT_I),
    .STALL_O                 (STALL_O),
    .ACK_O                   (ACK_O),
    .DAT_O                   (DAT_O),
    .client_request_get      (client_request_get),
    .RDY_client_request_get  (RDY_client_request_get),
    .EN_client_request_get   (EN_client_request_get),
    .client_response_put     (client_response_put),
    .RDY_client_response_put (RDY_client_response_put),
    .EN_client_response_put  (EN_client_response_put)
  );

  // Reference model state
  wb_req_t     reqq[$];
  wb_req_t     infq[$];
  int          drop_m = 0;
  logic        ack_m  = 1'b0;
  logic [31:0] dat_m  = '0;

  int   checks = 0, errors = 0;
  int   acc_cnt = 0, ack_cnt = 0, resp_n = 0;
  logic last_acc = 1'b0;

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int owed();
    return infq.size() + drop_m;
  endfunction

  task automatic bus(input logic cyc, stb, we, input logic [31:0] adr, dat);
    CYC_I = cyc; STB_I = stb; WE_I = we; SEL_I = 4'hF; ADR_I = adr; DAT_I = dat;
  endtask

  task automatic cli(input logic deq, put, input logic [31:0] resp);
    EN_client_request_get = deq; EN_client_response_put = put; client_response_put = resp;
  endtask

  // One clock: predict acceptance, advance the model at the edge, compare after.
  task automatic tick();
    int tot;
    wb_req_t r;
    tot = reqq.size() + owed();
    last_acc = RST_N && CYC_I && STB_I && (tot != MAXO);
    @(posedge CLK);
    if (!RST_N) begin
      reqq.delete(); infq.delete(); drop_m = 0; ack_m = 1'b0; dat_m = '0;
    end else begin
      if (EN_client_request_get) infq.push_back(reqq.pop_front());
      ack_m = 1'b0;
      if (!CYC_I) begin
        drop_m += infq.size() - int'(EN_client_response_put);
        infq.delete(); reqq.delete();
      end else begin
        if (last_acc) begin
          r = '{we: WE_I, sel: SEL_I, adr: ADR_I, dat: DAT_I};
          reqq.push_back(r);
          acc_cnt++;
        end
        if (EN_client_response_put) begin
          if (drop_m > 0) drop_m--;
          else begin
            void'(infq.pop_front());
            ack_m = 1'b1;
            dat_m = client_response_put;
          end
        end
      end
    end
    #1;
    if (ACK_O === 1'b1) ack_cnt++;
    tot = reqq.size() + owed();
    chk("ack", ACK_O, ack_m);
    chk("dat", DAT_O, dat_m);
    chk("stall", STALL_O, !RST_N || (tot == MAXO));
    chk("rdy_get", RDY_client_request_get, RST_N && (reqq.size() > 0));
    chk("rdy_put", RDY_client_response_put, RST_N && (owed() > 0));
    if (reqq.size() > 0) chk("head", client_request_get, reqq[0]);
  endtask

  // Client serves everything outstanding while CYC_I stays high; a held STB
  // is released once it is accepted.
  task automatic drain(input int budget);
    int n = 0;
    while (n < budget && (STB_I || reqq.size() > 0 || owed() > 0)) begin
      EN_client_request_get  = (reqq.size() > 0);
      EN_client_response_put = (owed() > 0);
      client_response_put    = 32'hA500_0000 + resp_n;
      if (EN_client_response_put) resp_n++;
      tick();
      if (last_acc) STB_I = 1'b0;
      n++;
    end
    cli(0, 0, 0);
    STB_I = 1'b0;
    chk("drain_done", {RDY_client_request_get, RDY_client_response_put}, 0);
  endtask

  initial begin
    RST_N = 1'b0;
    bus(0, 0, 0, 0, 0);
    cli(0, 0, 0);
    #1;
    // Reset
    tick(); tick();
    chk("rst_stall", STALL_O, 1);
    chk("rst_ack", ACK_O, 0);
    RST_N = 1'b1;
    tick();
    chk("rel_stall", STALL_O, 0);

    // Single read: ACK two cycles after acceptance
    bus(1, 1, 0, 32'h100, 0); tick();
    chk("rd_acc", last_acc, 1);
    bus(1, 0, 0, 0, 0); cli(1, 0, 0); tick();
    cli(0, 1, 32'hDEADBEEF); tick();
    chk("rd_ack", ACK_O, 1);
    chk("rd_dat", DAT_O, 32'hDEADBEEF);
    cli(0, 0, 0); tick();
    chk("rd_ack_pulse", ACK_O, 0);
    chk("rd_dat_hold", DAT_O, 32'hDEADBEEF);

    // Burst of 8 writes with an idle client, then a held 9th strobe
    ack_cnt = 0; acc_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      bus(1, 1, 1, 32'h200 + 4 * k, 32'hC0DE_0000 + k); tick();
      chk("burst_acc", last_acc, 1);
    end
    chk("burst_full", STALL_O, 1);
    bus(1, 1, 1, 32'h220, 32'hC0DE_0008); tick();
    chk("burst_hold9", last_acc, 0);
    drain(60);
    chk("burst_accs", acc_cnt, 9);
    chk("burst_acks", ack_cnt, 9);

    // Abort with 2 queued and 2 in flight
    ack_cnt = 0;
    for (int k = 0; k < 4; k++) begin bus(1, 1, 0, 32'h280 + 4 * k, 0); tick(); end
    bus(1, 0, 0, 0, 0); cli(1, 0, 0); tick(); tick();
    cli(0, 0, 0); bus(0, 0, 0, 0, 0); tick();
    chk("abort_q_flushed", RDY_client_request_get, 0);
    chk("abort_owed", RDY_client_response_put, 1);
    chk("abort_no_ack", ACK_O, 0);
    bus(1, 1, 0, 32'h300, 0); cli(0, 1, 32'h1111_1111); tick();
    chk("drop1_no_ack", ACK_O, 0);
    bus(1, 0, 0, 0, 0); cli(1, 1, 32'h2222_2222); tick();
    chk("drop2_no_ack", ACK_O, 0);
    cli(0, 1, 32'h3333_3333); tick();
    chk("after_drop_ack", ACK_O, 1);
    chk("after_drop_dat", DAT_O, 32'h3333_3333);
    cli(0, 0, 0); tick();
    chk("abort_acks", ack_cnt, 1);

    // Put coincident with CYC_I falling, one in flight
    bus(1, 1, 0, 32'h400, 0); tick();
    bus(1, 0, 0, 0, 0); cli(1, 0, 0); tick();
    bus(0, 0, 0, 0, 0); cli(0, 1, 32'h4444_4444); tick();
    chk("fall_put_no_ack", ACK_O, 0);
    chk("fall_put_no_drop", RDY_client_response_put, 0);
    cli(0, 0, 0); bus(1, 0, 0, 0, 0); tick();

    // Reset mid-operation: 3 queued, 2 in flight
    for (int k = 0; k < 5; k++) begin bus(1, 1, 1, 32'h500 + 4 * k, k); tick(); end
    bus(1, 0, 0, 0, 0); cli(1, 0, 0); tick(); tick();
    cli(0, 0, 0);
    RST_N = 1'b0;
    #1;
    chk("rst_comb_stall", STALL_O, 1);
    tick();
    chk("mid_rst_ack", ACK_O, 0);
    chk("mid_rst_rdy", {RDY_client_request_get, RDY_client_response_put}, 0);
    RST_N = 1'b1;
    tick();
    chk("mid_rel_stall", STALL_O, 0);

    // Random bus and client traffic
    for (int b = 0; b < 60; b++) begin
      int len;
      len = $urandom_range(4, 30);
      acc_cnt = 0; ack_cnt = 0;
      CYC_I = 1'b1;
      for (int c = 0; c < len; c++) begin
        STB_I = $urandom_range(0, 1); WE_I = $urandom_range(0, 1);
        SEL_I = $urandom; ADR_I = $urandom; DAT_I = $urandom;
        EN_client_request_get  = (reqq.size() > 0) && ($urandom_range(0, 1) == 1);
        EN_client_response_put = (owed() > 0) && ($urandom_range(0, 2) != 0);
        client_response_put    = $urandom;
        tick();
        chk("rand_ack_le_acc", ack_cnt <= acc_cnt, 1);
      end
      if ($urandom_range(0, 1) == 1) begin
        drain(64);
        chk("rand_acks_eq", ack_cnt, acc_cnt);
      end
      chk("rand_ack_bound", ack_cnt <= acc_cnt, 1);
      CYC_I = 1'b0;
      for (int c = 0; c < int'($urandom_range(1, 3)); c++) begin
        STB_I = $urandom_range(0, 1);
        EN_client_request_get  = (reqq.size() > 0) && ($urandom_range(0, 1) == 1);
        EN_client_response_put = (owed() > 0) && ($urandom_range(0, 1) == 1);
        client_response_put    = $urandom;
        tick();
      end
      cli(0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
